// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: streams the sixteen PC-2 round keys, one per clock,
// in encryption order (K1..K16) or decryption order (K16..K1).
module des_key_schedule (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [0:63] i_key,
  output logic        o_busy,
  output logic        o_kvalid,
  output logic [3:0]  o_round,
  output logic [0:47] o_subkey,
  output logic        o_done
);

  typedef enum logic {StIdle, StRun} state_e;

  // Zero-based source bit positions (bit 0 = MSB of the key)
  localparam int unsigned Pc1Tab [56] = '{
    56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
     9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
    62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
    13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
  };

  localparam int unsigned Pc2Tab [48] = '{
    13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
    22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
    40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
    43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
  };

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] o;
    for (int i = 0; i < 56; i++) begin
      o[i] = k[6'(Pc1Tab[i])];
    end
    return o;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] o;
    for (int i = 0; i < 48; i++) begin
      o[i] = cd[6'(Pc2Tab[i])];
    end
    return o;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] v, input logic one);
    return one ? {v[1:27], v[0]} : {v[2:27], v[0:1]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] v, input logic one);
    return one ? {v[27], v[0:26]} : {v[26:27], v[0:25]};
  endfunction

  state_e      r_state, w_state_d;
  logic [3:0]  r_n, w_n_d;
  logic [0:27] r_c, w_c_d;
  logic [0:27] r_d, w_d_d;
  logic        r_mode, w_mode_d;
  logic        r_kvalid, w_kvalid_d;
  logic        r_done, w_done_d;
  logic [3:0]  r_round, w_round_d;
  logic [0:47] r_subkey, w_subkey_d;

  logic        w_single;
  logic [0:55] w_pc1;
  logic [0:27] w_c_l, w_d_l, w_c_r, w_d_r;

  // Single-bit shifts land on rounds 1, 2, 9, 16; decryption walks them backwards.
  always_comb begin
    w_single = 1'b0;
    if (!r_mode) begin
      w_single = (r_n == 4'd0) || (r_n == 4'd1) || (r_n == 4'd8) || (r_n == 4'd15);
    end else begin
      w_single = (r_n == 4'd0) || (r_n == 4'd7) || (r_n == 4'd14) || (r_n == 4'd15);
    end
  end

  assign w_pc1 = pc1(i_key);
  assign w_c_l = rotl(r_c, w_single);
  assign w_d_l = rotl(r_d, w_single);
  assign w_c_r = rotr(r_c, w_single);
  assign w_d_r = rotr(r_d, w_single);

  always_comb begin
    w_state_d  = r_state;
    w_n_d      = r_n;
    w_c_d      = r_c;
    w_d_d      = r_d;
    w_mode_d   = r_mode;
    w_kvalid_d = 1'b0;
    w_done_d   = 1'b0;
    w_round_d  = r_round;
    w_subkey_d = r_subkey;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_c_d     = w_pc1[0:27];
          w_d_d     = w_pc1[28:55];
          w_mode_d  = i_mode;
          w_n_d     = 4'd0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_kvalid_d = 1'b1;
        w_n_d      = r_n + 4'd1;
        if (!r_mode) begin
          w_c_d      = w_c_l;
          w_d_d      = w_d_l;
          w_subkey_d = pc2({w_c_l, w_d_l});
          w_round_d  = r_n;
        end else begin
          // Emit from the current halves, then step back one round
          w_subkey_d = pc2({r_c, r_d});
          w_round_d  = 4'd15 - r_n;
          w_c_d      = w_c_r;
          w_d_d      = w_d_r;
        end
        if (r_n == 4'd15) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
          w_c_d     = '0;
          w_d_d     = '0;
          w_n_d     = 4'd0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_n      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_mode   <= 1'b0;
      r_kvalid <= 1'b0;
      r_done   <= 1'b0;
      r_round  <= '0;
      r_subkey <= '0;
    end else begin
      r_state  <= w_state_d;
      r_n      <= w_n_d;
      r_c      <= w_c_d;
      r_d      <= w_d_d;
      r_mode   <= w_mode_d;
      r_kvalid <= w_kvalid_d;
      r_done   <= w_done_d;
      r_round  <= w_round_d;
      r_subkey <= w_subkey_d;
    end
  end

  assign o_busy   = (r_state == StRun);
  assign o_kvalid = r_kvalid;
  assign o_done   = r_done;
  assign o_round  = r_round;
  assign o_subkey = r_subkey;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: known-answer subkeys, ordering, parity independence,
// busy-start rejection, mid-run reset and continuous-start throughput.
module tb_des_key_schedule;

  localparam logic [63:0] Key1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] Key2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] Key2p = 64'h0E329232EA6D0D72;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [63:0] key = '0;
  logic        busy, kvalid, done;
  logic [3:0]  round;
  logic [47:0] subkey;

  des_key_schedule dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_mode   (mode),
    .i_key    (key),
    .o_busy   (busy),
    .o_kvalid (kvalid),
    .o_round  (round),
    .o_subkey (subkey),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // K1..K16 for Key1
  logic [47:0] ktab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic [47:0] cap_sk [16];
  logic [3:0]  cap_rd [16];
  logic [47:0] e2 [16];
  int cap_n, cap_done_n, cap_done_idx, busy_err;

  task automatic run_sched(input logic [63:0] k, input logic m, input int poke_at);
    key   = k;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    if (k == Key1) begin
      check_eq("pc1_c0", dut.r_c, 28'hF0CCAAF);
      check_eq("pc1_d0", dut.r_d, 28'h556678F);
    end
    cap_n = 0; cap_done_n = 0; cap_done_idx = -1; busy_err = 0;
    for (int cyc = 0; cyc < 19; cyc++) begin
      @(posedge clk); #1;
      if (kvalid) begin
        if (cap_n < 16) begin
          cap_sk[cap_n] = subkey;
          cap_rd[cap_n] = round;
        end
        if (done) begin
          cap_done_n++;
          cap_done_idx = cap_n;
        end
        if (cap_n < 15 && !busy) busy_err++;
        cap_n++;
      end else if (done) begin
        cap_done_n++;
      end
      if (cyc == poke_at) begin
        start = 1'b1;
        key   = 64'hFEDCBA9876543210;
        mode  = ~m;
      end else if (cyc == poke_at + 1) begin
        start = 1'b0;
        key   = k;
        mode  = m;
      end
    end
    start = 1'b0;
    check_eq("kvalid_count", cap_n, 16);
    check_eq("done_count", cap_done_n, 1);
    check_eq("done_on_last", cap_done_idx, 15);
    check_eq("busy_in_run", busy_err, 0);
  endtask

  task automatic check_key1_enc(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s_k%0d", tag, i + 1), cap_sk[i], ktab[i]);
      check_eq($sformatf("%s_round%0d", tag, i), cap_rd[i], i);
    end
  endtask

  int bad, ndone, d1, d2, nkv, blow;
  logic busy_hist [41];

  initial begin
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_kvalid", kvalid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_round", round, 0);
    check_eq("rst_subkey", subkey, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_sched(Key1, 1'b0, -100);
    check_key1_enc("enc");

    run_sched(Key1, 1'b1, -100);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("dec_sk%0d", i), cap_sk[i], ktab[15 - i]);
      check_eq($sformatf("dec_round%0d", i), cap_rd[i], 15 - i);
    end

    run_sched(Key2, 1'b0, -100);
    for (int i = 0; i < 16; i++) e2[i] = cap_sk[i];
    run_sched(Key2, 1'b1, -100);
    for (int i = 0; i < 16; i++) check_eq($sformatf("k2_mirror%0d", i), cap_sk[i], e2[15 - i]);
    run_sched(Key2p, 1'b0, -100);
    for (int i = 0; i < 16; i++) check_eq($sformatf("k2_parity%0d", i), cap_sk[i], e2[i]);

    // start pulsed during RUN with another key and mode
    run_sched(Key1, 1'b0, 4);
    check_key1_enc("poke");

    key = Key1; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_kvalid", kvalid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_subkey", subkey, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (kvalid || busy || done || subkey != 48'h0) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);
    run_sched(Key1, 1'b0, -100);
    check_key1_enc("after_rst");

    key = Key1; mode = 1'b0; start = 1'b1;
    ndone = 0; d1 = -1; d2 = -1; nkv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      busy_hist[k] = busy;
      if (kvalid) nkv++;
      if (done) begin
        if (ndone == 0) d1 = k;
        else if (ndone == 1) d2 = k;
        ndone++;
      end
    end
    start = 1'b0;
    check_eq("cont_done_count", ndone, 2);
    check_eq("cont_done_spacing", d2 - d1, 17);
    check_eq("cont_kvalid_count", nkv, 37);
    blow = 0;
    if (d1 > 0 && d2 > d1) begin
      for (int k = d1; k < d2; k++) if (!busy_hist[k]) blow++;
    end
    check_eq("cont_busy_gap", blow, 1);
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
